fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have parameter dw, default 8, giving the data word width.
REQ-003 The block SHALL have parameter nr, default 4, giving the number of requesters (2..8).
REQ-004 The block SHALL have parameter bl, default 4, giving the maximum burst length in words (used only when FIFO_ARB_BURST_EN is defined).
REQ-005 Port clk SHALL be input, width 1: single clock (same domain as the FIFO write side).
REQ-006 Port rst SHALL be input, width 1: synchronous active-high reset.
REQ-007 Port req_valid SHALL be input, width nr: per-requester data valid.
REQ-008 Port req_data SHALL be input, width nr*dw: requester i occupies bits [i*dw +: dw].
REQ-009 Port req_ready SHALL be output, width nr: per-requester accept, at most one bit high.
REQ-010 Port wfull SHALL be input, width 1: FIFO write-side full flag.
REQ-011 Port winc SHALL be output, width 1: FIFO write strobe.
REQ-012 Port wdata SHALL be output, width dw: FIFO write data.
REQ-013 Port grant_id SHALL be output, width $clog2(nr): index of the last requester that transferred (registered).
REQ-014 Port wcount SHALL be output, width 16: total words written since reset (registered).
REQ-015 Port locked SHALL be output, width 1: high while state is LOCK.

Function
REQ-016 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 winc SHALL equal OR of (req_valid & req_ready), combinationally; wdata SHALL be req_data of the ready requester, or 0 when no transfer occurs.
REQ-018 req_ready SHALL be all zero whenever wfull is high; no write SHALL ever be issued while wfull is high.
REQ-019 In state IDLE/ARB the winner SHALL be the first requester with req_valid high, searching from rotating pointer ptr upward with wrap from nr-1 to 0.
REQ-020 After a transfer by requester i without a burst lock, ptr SHALL become (i+1) mod nr on the next clock edge.
REQ-021 A requester withdrawing req_valid with no transfer SHALL NOT change ptr.
REQ-022 grant_id SHALL load i on the clock edge after each transfer by i, and SHALL otherwise hold.
REQ-023 wcount SHALL increment by 1 on each transfer, wrapping from 65535 to 0.
REQ-024 FSM states SHALL be IDLE (no req_valid high), ARB (any req_valid high, no lock), and LOCK (burst in progress, only with FIFO_ARB_BURST_EN); locked SHALL be 0 outside LOCK.
REQ-025 With wfull high and requesters pending, the state SHALL hold and ptr SHALL not move; arbitration SHALL resume on the first cycle wfull is low.
REQ-026 Transfer latency SHALL be zero cycles from handshake to winc.

Reset
REQ-027 While rst is high at a clock edge: ptr=0, state=IDLE, grant_id=0, wcount=0, burst counter=0, locked=0.
REQ-028 While rst is high req_ready SHALL be all zero and winc SHALL be 0, combinationally.
REQ-029 Reset asserted mid-burst SHALL abandon the lock with no further writes; the next grant SHALL start from requester 0.

Configuration
REQ-030 Macro FIFO_ARB_BURST_EN SHALL enable burst lock.
REQ-031 With FIFO_ARB_BURST_EN defined, a transfer by i from ARB SHALL enter LOCK with burst count 1; in LOCK only requester i SHALL be eligible.
REQ-032 In LOCK, the block SHALL exit to ARB/IDLE with ptr=(i+1) mod nr when the burst count reaches bl, or when req_valid[i] is low in a cycle with wfull low.
REQ-033 In LOCK, wfull high SHALL stall the burst without releasing the lock.
REQ-034 Without FIFO_ARB_BURST_EN, LOCK SHALL not exist, parameter bl SHALL be ignored, and locked SHALL be tied to 0.

Verification
REQ-035 Reset test: rst=1 for 2 cycles with req_valid=4'b1111 -> winc=0, req_ready=0, grant_id=0, wcount=0.
REQ-036 Round-robin test (no macro): req_valid=4'b1111 held, wfull=0, req_data={8'h33,8'h22,8'h11,8'h00} -> wdata sequence 00,11,22,33,00 over 5 cycles; wcount=5.
REQ-037 Skip test: req_valid=4'b1010 -> grants alternate 1,3,1,3; requesters 0 and 2 are never ready.
REQ-038 Full test: wfull=1 for 3 cycles with all requesters valid -> winc=0 for those cycles; the grant on the first cycle with wfull low is the same requester as before the stall.
REQ-039 Burst test (FIFO_ARB_BURST_EN, bl=4): req_valid=4'b0011 -> requester 0 writes 4 consecutive words with locked=1, then requester 1 writes 4; a drop of req_valid[0] after 2 words releases the lock to requester 1.
REQ-040 Wrap test: preload 65534 transfers -> wcount goes 65535 then 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single FIFO write port; zero-latency handshake.
// Define FIFO_ARB_BURST_EN to let a granted requester hold the port for up to bl words.
module fifo_wr_arbiter #(
    parameter int dw = 8,
    parameter int nr = 4,
    parameter int bl = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [nr-1:0]           req_valid,
    input  logic [nr*dw-1:0]        req_data,
    output logic [nr-1:0]           req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [dw-1:0]           wdata,
    output logic [$clog2(nr)-1:0]   grant_id,
    output logic [15:0]             wcount,
    output logic                    locked
);

    localparam int IW = $clog2(nr);

    if (nr < 2 || nr > 8) begin : g_bad_nr
        $error("fifo_wr_arbiter: nr must be in 2..8");
    end
    if (bl < 1) begin : g_bad_bl
        $error("fifo_wr_arbiter: bl must be at least 1");
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(bl + 1);
    typedef enum logic [1:0] {IDLE, ARB, LOCK} state_t;
    logic [IW-1:0] lock_id, lock_id_n;
    logic [CW-1:0] cnt, cnt_n;
`else
    typedef enum logic [1:0] {IDLE, ARB} state_t;
`endif

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] win_idx, cand;
    logic          win_found;
    logic          grant;

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
        if (int'(i) == nr - 1) return '0;
        return i + 1'b1;
    endfunction

    // Winner search: first valid requester at or above ptr, wrapping; a lock pins the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < nr; k++) begin
            cand = IW'((int'(ptr) + k) % nr);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`ifdef FIFO_ARB_BURST_EN
        if (state == LOCK) begin
            win_found = req_valid[lock_id];
            win_idx   = lock_id;
        end
`endif
    end

    assign grant = win_found && !wfull && !rst;
    assign winc  = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            wcount   <= '0;
`ifdef FIFO_ARB_BURST_EN
            lock_id  <= '0;
            cnt      <= '0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
`ifdef FIFO_ARB_BURST_EN
            lock_id <= lock_id_n;
            cnt     <= cnt_n;
`endif
            if (winc) begin
                grant_id <= win_idx;
                wcount   <= wcount + 16'd1;
            end
        end
    end

    // A full FIFO freezes state and pointer; only a real transfer advances ptr.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
`ifdef FIFO_ARB_BURST_EN
        lock_id_n = lock_id;
        cnt_n     = cnt;
        if (state == LOCK) begin
            if (!wfull) begin
                if (req_valid[lock_id] && cnt != CW'(bl - 1)) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    state_n = (|req_valid) ? ARB : IDLE;
                    ptr_n   = inc_idx(lock_id);
                    cnt_n   = '0;
                end
            end
        end else begin
            if (!wfull) state_n = (|req_valid) ? ARB : IDLE;
            if (winc) begin
                if (bl > 1) begin
                    state_n   = LOCK;
                    cnt_n     = CW'(1);
                    lock_id_n = win_idx;
                end else begin
                    ptr_n = inc_idx(win_idx);
                end
            end
        end
`else
        if (!wfull) state_n = (|req_valid) ? ARB : IDLE;
        if (winc) ptr_n = inc_idx(win_idx);
`endif
    end

    always_comb begin
        req_ready = '0;
        wdata     = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
            wdata              = req_data[win_idx*dw +: dw];
        end
`ifdef FIFO_ARB_BURST_EN
        locked = (state == LOCK);
`else
        locked = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter; expected records flow through a scoreboard queue.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            wfull;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [1:0]      grant_id;
    logic [15:0]     wcount;
    logic            locked;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.dw(DW), .nr(NR), .bl(BL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_id(grant_id), .wcount(wcount), .locked(locked)
    );

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic       f;
        logic [3:0] rdy;
        logic       wi;
        logic [7:0] wd;
        logic       lk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    int m_wcount = 0;
    int m_grant = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] v, input logic f,
                                input logic [3:0] rdy, input logic [7:0] wd, input logic lk);
        vec_t t;
        t.r = r; t.v = v; t.f = f; t.rdy = rdy; t.wi = (rdy != 4'b0); t.wd = wd; t.lk = lk;
        tbl.push_back(t);
    endfunction

    function automatic int onehot_idx(input logic [3:0] oh);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge clk);
        rst = t.r; req_valid = t.v; wfull = t.f;
        sb.push_back(t);
        #1;
        e = sb.pop_front();
        check("req_ready", int'(req_ready), int'(e.rdy));
        check("winc", int'(winc), int'(e.wi));
        check("wdata", int'(wdata), int'(e.wd));
        check("locked", int'(locked), int'(e.lk));
        @(posedge clk);
        #1;
        if (e.r) begin
            m_wcount = 0;
            m_grant  = 0;
        end else if (e.wi) begin
            m_wcount = (m_wcount + 1) & 16'hFFFF;
            m_grant  = onehot_idx(e.rdy);
        end
        check("grant_id", int'(grant_id), m_grant);
        check("wcount", int'(wcount), m_wcount);
    endtask

    initial begin
        vec_t t;
        rst = 1'b1; req_valid = '0; wfull = 1'b0;
        req_data = {8'h33, 8'h22, 8'h11, 8'h00};

        add(1, 4'hF, 0, 4'h0, 8'h00, 0);
        add(1, 4'hF, 0, 4'h0, 8'h00, 0);
`ifdef FIFO_ARB_BURST_EN
        add(0, 4'h3, 0, 4'h1, 8'h00, 0);
        add(0, 4'h3, 0, 4'h1, 8'h00, 1);
        add(0, 4'h3, 0, 4'h1, 8'h00, 1);
        add(0, 4'h3, 0, 4'h1, 8'h00, 1);
        add(0, 4'h3, 0, 4'h2, 8'h11, 0);
        add(0, 4'h3, 0, 4'h2, 8'h11, 1);
        add(0, 4'h3, 0, 4'h2, 8'h11, 1);
        add(0, 4'h3, 0, 4'h2, 8'h11, 1);
        add(0, 4'h3, 0, 4'h1, 8'h00, 0);
        add(0, 4'h3, 0, 4'h1, 8'h00, 1);
        add(0, 4'h2, 0, 4'h0, 8'h00, 1);
        add(0, 4'h2, 0, 4'h2, 8'h11, 0);
        add(0, 4'h2, 1, 4'h0, 8'h00, 1);
        add(0, 4'h2, 0, 4'h2, 8'h11, 1);
        add(1, 4'h3, 0, 4'h0, 8'h00, 1);
        add(1, 4'h3, 0, 4'h0, 8'h00, 0);
        add(0, 4'h3, 0, 4'h1, 8'h00, 0);
`else
        add(0, 4'hF, 0, 4'h1, 8'h00, 0);
        add(0, 4'hF, 0, 4'h2, 8'h11, 0);
        add(0, 4'hF, 0, 4'h4, 8'h22, 0);
        add(0, 4'hF, 0, 4'h8, 8'h33, 0);
        add(0, 4'hF, 0, 4'h1, 8'h00, 0);
        add(0, 4'hA, 0, 4'h2, 8'h11, 0);
        add(0, 4'hA, 0, 4'h8, 8'h33, 0);
        add(0, 4'hA, 0, 4'h2, 8'h11, 0);
        add(0, 4'hA, 0, 4'h8, 8'h33, 0);
        add(0, 4'h0, 0, 4'h0, 8'h00, 0);
        add(0, 4'hF, 0, 4'h1, 8'h00, 0);
        add(0, 4'hF, 1, 4'h0, 8'h00, 0);
        add(0, 4'hF, 1, 4'h0, 8'h00, 0);
        add(0, 4'hF, 1, 4'h0, 8'h00, 0);
        add(0, 4'hF, 0, 4'h2, 8'h11, 0);
        add(0, 4'h4, 0, 4'h4, 8'h22, 0);
        add(0, 4'h1, 0, 4'h1, 8'h00, 0);
        add(1, 4'hF, 0, 4'h0, 8'h00, 0);
        add(0, 4'hF, 0, 4'h1, 8'h00, 0);
`endif

        foreach (tbl[i]) apply(tbl[i]);

        // Counter wrap: reset, preload 65534 single-requester writes, then two more.
        t.r = 1; t.v = 4'h0; t.f = 0; t.rdy = 4'h0; t.wi = 0; t.wd = 8'h00; t.lk = 0;
        apply(t);
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            rst = 1'b0; req_valid = 4'h1; wfull = 1'b0;
        end
        @(posedge clk);
        #1;
        m_wcount = 65534;
        m_grant  = 0;
        check("wcount_preload", int'(wcount), m_wcount);
        req_data = {8'h33, 8'h22, 8'h11, 8'h5A};
        t.r = 0; t.v = 4'h1; t.f = 0; t.rdy = 4'h1; t.wi = 1; t.wd = 8'h5A;
`ifdef FIFO_ARB_BURST_EN
        t.lk = 1'b1;
`else
        t.lk = 1'b0;
`endif
        apply(t);
        apply(t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
